vote_tally: RTL and testbench

- Parametrised successor to the 4-candidate vote logger, generalised to NUM_CAND candidates with CNT_W-bit tallies.
- Adds officer-armed ballots (one vote per arm), rejection of multi-press votes, a post-vote lockout, saturating counters, a running total, and leader/tie detection.
- Sits between the debounced candidate buttons and the display/result mux.
- Tallies are hidden (read as zero) outside result mode.

---
 rtl/vote_tally.sv | 139 +++++++++++++
 tb/tb_vote_tally.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally.sv
// Ballot tally controller: officer-armed single votes, multi-press rejection,
// post-vote lockout, saturating per-candidate counters and leader/tie detection.
//
// state  | meaning
// IDLE   | waiting for the officer to arm a ballot
// ARMED  | one ballot open; a single button press counts, more than one is rejected
// LOCK   | post-vote lockout, LOCKOUT_CYC cycles, buttons ignored
// RESULT | tallies, total and leader are visible on the outputs
module vote_tally #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int LOCKOUT_CYC = 4,
    parameter int TOT_W       = CNT_W + $clog2(NUM_CAND),
    parameter int IDX_W       = $clog2(NUM_CAND)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mode,
    input  logic                      ballot_arm,
    input  logic [NUM_CAND-1:0]       vote_valid,
    output logic [NUM_CAND*CNT_W-1:0] cand_count,
    output logic [TOT_W-1:0]          total_votes,
    output logic [IDX_W-1:0]          leader_idx,
    output logic                      leader_tie,
    output logic                      ready,
    output logic                      vote_accepted,
    output logic                      vote_rejected,
    output logic                      sat_flag
);

    localparam int LK_W = $clog2(LOCKOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, LOCK, RESULT} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   tally [NUM_CAND];
    logic [TOT_W-1:0]   total;
    logic [LK_W-1:0]    lock_cnt;
    logic               one_hot, multi;
    logic [IDX_W-1:0]   vote_idx;
    logic               accept, reject;
    logic [CNT_W-1:0]   max_val;
    logic [IDX_W-1:0]   lead;
    logic               tie;
    logic               in_result;

    // A single press is a nonzero vector with no second bit set.
    always_comb begin
        one_hot  = (vote_valid != '0) &&
                   ((vote_valid & (vote_valid - NUM_CAND'(1))) == '0);
        multi    = (vote_valid != '0) && !one_hot;
        vote_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_valid[i]) vote_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        if (mode) begin
            state_next = RESULT;
        end else begin
            case (state)
                IDLE:   if (ballot_arm) state_next = ARMED;
                ARMED: begin
                    if (one_hot) begin
                        accept     = 1'b1;
                        state_next = LOCK;
                    end else if (multi) begin
                        reject = 1'b1;
                    end
                end
                LOCK:   if (lock_cnt <= LK_W'(1)) state_next = IDLE;
                RESULT: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            lock_cnt      <= '0;
            total         <= '0;
            sat_flag      <= 1'b0;
            vote_accepted <= 1'b0;
            vote_rejected <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
        end else begin
            state         <= state_next;
            vote_accepted <= accept;
            vote_rejected <= reject;
            if (accept) begin
                lock_cnt <= LK_W'(LOCKOUT_CYC);
                if (tally[vote_idx] == CNT_MAX) begin
                    sat_flag <= 1'b1;
                end else begin
                    tally[vote_idx] <= tally[vote_idx] + CNT_W'(1);
                    total           <= total + TOT_W'(1);
                end
            end else if (state == LOCK && lock_cnt != '0) begin
                lock_cnt <= lock_cnt - LK_W'(1);
            end
        end
    end

    // Lowest index wins among equal maxima; any repeat of the maximum is a tie.
    always_comb begin
        max_val = tally[0];
        lead    = '0;
        tie     = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally[i] > max_val) begin
                max_val = tally[i];
                lead    = IDX_W'(i);
                tie     = 1'b0;
            end else if (tally[i] == max_val) begin
                tie = 1'b1;
            end
        end
    end

    assign in_result = (state == RESULT);
    assign ready     = (state == ARMED);

    always_comb begin
        cand_count = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            cand_count[i*CNT_W +: CNT_W] = in_result ? tally[i] : '0;
        end
        total_votes = in_result ? total : '0;
        leader_idx  = in_result ? lead : '0;
        leader_tie  = in_result & tie;
    end

endmodule

// File: tb/tb_vote_tally.sv
// Scoreboard bench for vote_tally: a wide-counter instance and a 2-bit-counter
// instance share stimulus; accept/reject pulses are matched against a queue.
module tb_vote_tally;

    localparam int NC  = 4;
    localparam int CW  = 8;
    localparam int CWS = 2;
    localparam int L   = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          mode = 1'b0;
    logic          ballot_arm = 1'b0;
    logic [NC-1:0] vote_valid = '0;

    logic [NC*CW-1:0]  cand_count;
    logic [CW+1:0]     total_votes;
    logic [1:0]        leader_idx;
    logic              leader_tie, ready, vote_accepted, vote_rejected, sat_flag;

    logic [NC*CWS-1:0] cand_count_s;
    logic [CWS+1:0]    total_s;
    logic [1:0]        leader_idx_s;
    logic              leader_tie_s, ready_s, acc_s, rej_s, sat_s;

    int errors = 0;
    int checks = 0;
    int acc_seen = 0;
    int acc_seen_s = 0;
    int exp_q[$];

    int exp_t[NC];
    int exp_ts[NC];
    int exp_tot, exp_tots;

    vote_tally #(.NUM_CAND(NC), .CNT_W(CW), .LOCKOUT_CYC(L)) dut (
        .clock(clock), .reset(reset), .mode(mode), .ballot_arm(ballot_arm),
        .vote_valid(vote_valid), .cand_count(cand_count), .total_votes(total_votes),
        .leader_idx(leader_idx), .leader_tie(leader_tie), .ready(ready),
        .vote_accepted(vote_accepted), .vote_rejected(vote_rejected), .sat_flag(sat_flag)
    );

    vote_tally #(.NUM_CAND(NC), .CNT_W(CWS), .LOCKOUT_CYC(L)) dut_s (
        .clock(clock), .reset(reset), .mode(mode), .ballot_arm(ballot_arm),
        .vote_valid(vote_valid), .cand_count(cand_count_s), .total_votes(total_s),
        .leader_idx(leader_idx_s), .leader_tie(leader_tie_s), .ready(ready_s),
        .vote_accepted(acc_s), .vote_rejected(rej_s), .sat_flag(sat_s)
    );

    always #5 clock = ~clock;

    // Pulse code: 1 = accepted, 2 = rejected; both instances must agree with the queue.
    always @(negedge clock) begin
        int code, code_s, e;
        code   = (vote_accepted === 1'b1 ? 1 : 0) + (vote_rejected === 1'b1 ? 2 : 0);
        code_s = (acc_s === 1'b1 ? 1 : 0) + (rej_s === 1'b1 ? 2 : 0);
        if (code != 0 || code_s != 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: got %0d/%0d, required none", code, code_s);
            end else begin
                e = exp_q.pop_front();
                if (code !== e || code_s !== e) begin
                    errors++;
                    $display("FAIL pulse_kind: got %0d/%0d, required %0d", code, code_s, e);
                end
            end
            if (code == 1) acc_seen++;
            if (code_s == 1) acc_seen_s++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            exp_t[i]  = 0;
            exp_ts[i] = 0;
        end
        exp_tot  = 0;
        exp_tots = 0;
    endtask

    function automatic logic [NC*CW-1:0] exp_counts();
        logic [NC*CW-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[i*CW +: CW] = exp_t[i][CW-1:0];
        return r;
    endfunction

    function automatic logic [NC*CWS-1:0] exp_counts_s();
        logic [NC*CWS-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[i*CWS +: CWS] = exp_ts[i][CWS-1:0];
        return r;
    endfunction

    function automatic int max_of(input int t[NC]);
        int m;
        m = 0;
        for (int i = 0; i < NC; i++) if (t[i] > m) m = t[i];
        return m;
    endfunction

    function automatic int exp_lead(input int t[NC]);
        int m;
        m = max_of(t);
        for (int i = NC - 1; i >= 0; i--) if (t[i] == m) exp_lead = i;
    endfunction

    function automatic bit exp_tie(input int t[NC]);
        int m, n;
        m = max_of(t);
        n = 0;
        for (int i = 0; i < NC; i++) if (t[i] == m) n++;
        return n > 1;
    endfunction

    task automatic do_reset();
        reset = 1'b1; mode = 1'b0; ballot_arm = 1'b0; vote_valid = '0;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic arm();
        ballot_arm = 1'b1;
        tick();
        ballot_arm = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL arm_ready: got %b, required 1", ready);
        end
    endtask

    // Drives one ARMED-cycle vector and records the expected pulse and tally effect.
    task automatic cast(input logic [NC-1:0] v);
        int n, idx;
        n   = $countones(v);
        idx = 0;
        for (int i = 0; i < NC; i++) if (v[i]) idx = i;
        vote_valid = v;
        if (n == 1) begin
            exp_q.push_back(1);
            if (exp_t[idx] < (1 << CW) - 1) begin
                exp_t[idx]++;
                exp_tot++;
            end
            if (exp_ts[idx] < (1 << CWS) - 1) begin
                exp_ts[idx]++;
                exp_tots++;
            end
        end else if (n > 1) begin
            exp_q.push_back(2);
        end
        tick();
        vote_valid = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cand_count, total_votes, leader_idx, leader_tie, ready,
             vote_accepted, vote_rejected, sat_flag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h/%h/%b%b%b%b%b, required all 0",
                     cand_count, total_votes, leader_idx, leader_tie, ready,
                     vote_accepted, vote_rejected, sat_flag);
        end
        checks++;
        if (sat_s !== 1'b0 || cand_count_s !== '0) begin
            errors++;
            $display("FAIL reset_small: got sat=%b counts=%h, required 0/0", sat_s, cand_count_s);
        end
    endtask

    task automatic test_basic();
        int a0;
        a0 = acc_seen;
        arm(); cast(4'b0001); repeat (L) tick();
        arm(); cast(4'b0100); repeat (L) tick();
        mode = 1'b1;
        tick();
        checks++;
        if (cand_count !== 32'h0001_0001 || cand_count !== exp_counts()) begin
            errors++;
            $display("FAIL basic_counts: got %h, required 00010001", cand_count);
        end
        checks++;
        if (total_votes !== 10'd2) begin
            errors++;
            $display("FAIL basic_total: got %0d, required 2", total_votes);
        end
        checks++;
        if (leader_idx !== 2'(exp_lead(exp_t)) || leader_tie !== exp_tie(exp_t) || leader_tie !== 1'b1) begin
            errors++;
            $display("FAIL basic_leader: got idx=%0d tie=%b, required idx=0 tie=1", leader_idx, leader_tie);
        end
        checks++;
        if (acc_seen - a0 != 2) begin
            errors++;
            $display("FAIL basic_accepts: got %0d, required 2", acc_seen - a0);
        end
        mode = 1'b0;
        tick();
    endtask

    task automatic test_reject();
        arm();
        cast(4'b0011);
        checks++;
        if (vote_rejected !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reject_pulse: got rej=%b ready=%b, required 1/1", vote_rejected, ready);
        end
        tick();
        checks++;
        if (vote_rejected !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reject_width: got rej=%b ready=%b, required 0/1", vote_rejected, ready);
        end
        cast(4'b0010);
        checks++;
        if (vote_accepted !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL retry_accept: got acc=%b ready=%b, required 1/0", vote_accepted, ready);
        end
        repeat (L) tick();
        mode = 1'b1;
        tick();
        checks++;
        if (cand_count !== exp_counts() || total_votes !== 10'(exp_tot)) begin
            errors++;
            $display("FAIL reject_counts: got %h total=%0d, required %h total=%0d",
                     cand_count, total_votes, exp_counts(), exp_tot);
        end
        mode = 1'b0;
        tick();
    endtask

    task automatic test_lockout();
        arm();
        cast(4'b0001);
        vote_valid = 4'b1000;
        for (int c = 1; c <= L + 2; c++) begin
            tick();
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL lock_ready c=%0d: got %b, required 0", c, ready);
            end
        end
        vote_valid = '0;
        arm();
        ballot_arm = 1'b1;
        cast(4'b0001);
        for (int c = 1; c <= L + 1; c++) begin
            tick();
            checks++;
            if (ready !== (c == L + 1)) begin
                errors++;
                $display("FAIL lock_exit c=%0d: got ready=%b, required %b", c, ready, c == L + 1);
            end
        end
        ballot_arm = 1'b0;
        mode = 1'b1;
        tick();
        checks++;
        if (cand_count !== exp_counts() || cand_count[3*CW +: CW] !== 8'd0) begin
            errors++;
            $display("FAIL lock_counts: got %h, required %h", cand_count, exp_counts());
        end
        mode = 1'b0;
        tick();
    endtask

    task automatic test_result_gating();
        do_reset();
        repeat (5) begin
            arm(); cast(4'b0001); repeat (L) tick();
        end
        checks++;
        if (cand_count !== '0 || total_votes !== '0 || leader_tie !== 1'b0) begin
            errors++;
            $display("FAIL gate_hidden: got %h total=%0d tie=%b, required 0/0/0",
                     cand_count, total_votes, leader_tie);
        end
        mode = 1'b1;
        tick();
        checks++;
        if (cand_count !== 32'd5 || total_votes !== 10'd5 || leader_idx !== 2'd0 || leader_tie !== 1'b0) begin
            errors++;
            $display("FAIL gate_shown: got %h total=%0d idx=%0d tie=%b, required 5/5/0/0",
                     cand_count, total_votes, leader_idx, leader_tie);
        end
        mode = 1'b0;
        tick();
        arm();
        vote_valid = 4'b0001;
        mode = 1'b1;
        tick();
        vote_valid = '0;
        tick();
        checks++;
        if (ready !== 1'b0 || cand_count !== 32'd5 || total_votes !== 10'd5) begin
            errors++;
            $display("FAIL armed_cancel: got ready=%b %h total=%0d, required 0/5/5",
                     ready, cand_count, total_votes);
        end
        mode = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        int a0;
        do_reset();
        a0 = acc_seen_s;
        for (int k = 0; k < 4; k++) begin
            arm();
            cast(4'b0100);
            checks++;
            if (sat_s !== (k == 3) || sat_flag !== 1'b0) begin
                errors++;
                $display("FAIL sat_flag vote%0d: got %b/%b, required %b/0", k, sat_s, sat_flag, k == 3);
            end
            repeat (L) tick();
        end
        mode = 1'b1;
        tick();
        checks++;
        if (cand_count_s !== 8'h30 || cand_count_s !== exp_counts_s() || total_s !== 4'(exp_tots) || total_s !== 4'd3) begin
            errors++;
            $display("FAIL sat_counts: got %h total=%0d, required 30 total=3", cand_count_s, total_s);
        end
        checks++;
        if (cand_count !== 32'h0004_0000 || total_votes !== 10'd4) begin
            errors++;
            $display("FAIL wide_counts: got %h total=%0d, required 00040000 total=4", cand_count, total_votes);
        end
        checks++;
        if (leader_idx_s !== 2'd2 || leader_tie_s !== 1'b0) begin
            errors++;
            $display("FAIL sat_leader: got idx=%0d tie=%b, required 2/0", leader_idx_s, leader_tie_s);
        end
        checks++;
        if (acc_seen_s - a0 != 4) begin
            errors++;
            $display("FAIL sat_accepts: got %0d, required 4", acc_seen_s - a0);
        end
        mode = 1'b0;
        tick();
        checks++;
        if (sat_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky: got %b, required 1", sat_s);
        end
    endtask

    task automatic test_reset_mid();
        arm();
        cast(4'b0010);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        checks++;
        if ({cand_count, total_votes, leader_idx, leader_tie, ready,
             vote_accepted, vote_rejected, sat_flag, sat_s} !== '0) begin
            errors++;
            $display("FAIL reset_lock: got ready=%b acc=%b sat=%b/%b, required all 0",
                     ready, vote_accepted, sat_flag, sat_s);
        end
        mode = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (leader_tie !== 1'b0 || ready !== 1'b0 || cand_count !== '0) begin
            errors++;
            $display("FAIL reset_result: got tie=%b ready=%b, required 0/0", leader_tie, ready);
        end
        reset = 1'b0;
        mode  = 1'b0;
        arm();
        mode = 1'b1;
        tick();
        checks++;
        if (cand_count !== '0 || total_votes !== '0 || leader_idx !== 2'd0 ||
            leader_tie !== 1'b1 || leader_tie_s !== 1'b1) begin
            errors++;
            $display("FAIL reset_cleared: got %h total=%0d idx=%0d tie=%b/%b, required 0/0/0/1/1",
                     cand_count, total_votes, leader_idx, leader_tie, leader_tie_s);
        end
        mode = 1'b0;
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_reject();
        test_lockout();
        test_result_gating();
        test_saturate();
        test_reset_mid();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pulses_missing: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
